// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Serial pattern detector with a runtime-loadable pattern, length
//            and overlap mode, a registered match pulse and a match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x_valid,
    input  logic               x,
    input  logic               clear,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [MAX_LEN-1:0] c_def_pattern = MAX_LEN'(4'b0110);
    localparam logic [LEN_W-1:0]   c_def_len     = LEN_W'(4);
    localparam logic [LEN_W-1:0]   c_min_len     = LEN_W'(2);
    localparam logic [LEN_W-1:0]   c_max_len     = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]   c_cnt_max     = '1;

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_seen;
    logic               r_z;
    logic [CNT_W-1:0]   r_count;

    logic               w_cfg_err;
    logic               w_valid_bit;
    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_seen_inc;
    logic               w_match;

    assign w_cfg_err   = (r_len < c_min_len) || (r_len > c_max_len);
    assign w_valid_bit = x_valid && !cfg_load;
    assign w_hist_next = {r_hist[MAX_LEN-2:0], x};
    assign w_seen_inc  = (r_seen >= r_len) ? r_len : (r_seen + LEN_W'(1));

    // Only the low len bits of pattern and history take part in the compare
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_match = w_valid_bit && !w_cfg_err && (w_seen_inc == r_len) &&
                     ((w_hist_next & w_mask) == (r_pattern & w_mask));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pattern <= c_def_pattern;
            r_len     <= c_def_len;
            r_overlap <= 1'b0;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_seen <= '0;
            r_z    <= 1'b0;
        end else begin
            r_z <= w_match;
            if (cfg_load) begin
                r_hist <= '0;
                r_seen <= '0;
            end else if (x_valid) begin
                r_hist <= w_hist_next;
                // Non-overlapping mode forces a full fresh pattern after a hit
                r_seen <= (w_match && !r_overlap) ? '0 : w_seen_inc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_match && (r_count != c_cnt_max)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign z           = r_z;
    assign match_count = r_count;
    assign cfg_err     = w_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Purpose  : Directed self-checking bench for seq_detector_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 5;

    logic               clock;
    logic               reset;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               x_valid;
    logic               x;
    logic               clear;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    int n_cmp;
    int n_err;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .x_valid     (x_valid),
        .x           (x),
        .clear       (clear),
        .z           (z),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic b, input logic ez, input string tag);
        x_valid = 1'b1;
        x       = b;
        step();
        x_valid = 1'b0;
        clear   = 1'b0;
        check(tag, 32'(z), 32'(ez));
    endtask

    task automatic send_nc(input logic b);
        x_valid = 1'b1;
        x       = b;
        step();
        x_valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        x_valid = 1'b0;
        x       = 1'b1;
        step();
        check(tag, 32'(z), 32'd0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input logic ov);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        x_valid     = 1'b1;
        x           = 1'b0;
        step();
        cfg_load    = 1'b0;
        x_valid     = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        x_valid     = 1'b0;
        x           = 1'b0;
        clear       = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_z", 32'(z), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);

        // Default configuration: 0110, non-overlapping
        send(1'b0, 1'b0, "def_b1");
        send(1'b1, 1'b0, "def_b2");
        send(1'b1, 1'b0, "def_b3");
        send(1'b0, 1'b1, "def_b4");
        idle("def_after");
        check("def_count", 32'(match_count), 32'd1);

        // Overlapping 0110 on 0110110 -> hits at bits 4 and 7
        load(8'h06, 5'd4, 1'b1);
        send(1'b0, 1'b0, "ov_b1");
        send(1'b1, 1'b0, "ov_b2");
        send(1'b1, 1'b0, "ov_b3");
        send(1'b0, 1'b1, "ov_b4");
        send(1'b1, 1'b0, "ov_b5");
        send(1'b1, 1'b0, "ov_b6");
        send(1'b0, 1'b1, "ov_b7");
        check("ov_count", 32'(match_count), 32'd3);

        // Non-overlapping: only the first hit
        load(8'h06, 5'd4, 1'b0);
        send(1'b0, 1'b0, "nov_b1");
        send(1'b1, 1'b0, "nov_b2");
        send(1'b1, 1'b0, "nov_b3");
        send(1'b0, 1'b1, "nov_b4");
        send(1'b1, 1'b0, "nov_b5");
        send(1'b1, 1'b0, "nov_b6");
        send(1'b0, 1'b0, "nov_b7");
        check("nov_count", 32'(match_count), 32'd4);

        // Invalid lengths
        load(8'h01, 5'd1, 1'b1);
        check("len1_err", 32'(cfg_err), 32'd1);
        send(1'b1, 1'b0, "len1_b1");
        send(1'b1, 1'b0, "len1_b2");
        send(1'b0, 1'b0, "len1_b3");
        send(1'b1, 1'b0, "len1_b4");
        check("len1_count", 32'(match_count), 32'd4);
        load(8'h06, 5'd9, 1'b1);
        check("len9_err", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 10; i++) send(i[0], 1'b0, "len9_z");
        check("len9_count", 32'(match_count), 32'd4);

        // Full-width pattern A5 = 10100101
        load(8'hA5, 5'd8, 1'b0);
        check("len8_err", 32'(cfg_err), 32'd0);
        send(1'b1, 1'b0, "a5_b1");
        send(1'b0, 1'b0, "a5_b2");
        send(1'b1, 1'b0, "a5_b3");
        send(1'b0, 1'b0, "a5_b4");
        send(1'b0, 1'b0, "a5_b5");
        send(1'b1, 1'b0, "a5_b6");
        send(1'b0, 1'b0, "a5_b7");
        send(1'b1, 1'b1, "a5_b8");
        check("a5_count", 32'(match_count), 32'd5);

        // Gaps in x_valid; upper pattern bits beyond len are don't-care
        load(8'hF6, 5'd4, 1'b0);
        send(1'b0, 1'b0, "gap_b1");
        idle("gap_i1");
        send(1'b1, 1'b0, "gap_b2");
        idle("gap_i2");
        idle("gap_i3");
        send(1'b1, 1'b0, "gap_b3");
        idle("gap_i4");
        send(1'b0, 1'b1, "gap_b4");
        idle("gap_i5");
        check("gap_count", 32'(match_count), 32'd6);

        // Saturation of the counter
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_count", 32'(match_count), 32'd0);
        for (int i = 0; i < 255; i++) begin
            send_nc(1'b0);
            send_nc(1'b1);
            send_nc(1'b1);
            send_nc(1'b0);
        end
        check("sat_pre", 32'(match_count), 32'd255);
        send(1'b0, 1'b0, "sat_b1");
        send(1'b1, 1'b0, "sat_b2");
        send(1'b1, 1'b0, "sat_b3");
        send(1'b0, 1'b1, "sat_b4");
        check("sat_hold", 32'(match_count), 32'd255);

        // Clear coincident with a match: clear wins, z still pulses
        send(1'b0, 1'b0, "cm_b1");
        send(1'b1, 1'b0, "cm_b2");
        send(1'b1, 1'b0, "cm_b3");
        clear = 1'b1;
        send(1'b0, 1'b1, "cm_b4");
        check("cm_count", 32'(match_count), 32'd0);

        // Reset mid-sequence, asserted away from a clock edge
        load(8'h5A, 5'd6, 1'b1);
        send(1'b0, 1'b0, "mr_b1");
        load(8'h06, 5'd4, 1'b0);
        send(1'b0, 1'b0, "mr_p1");
        send(1'b1, 1'b0, "mr_p2");
        send(1'b1, 1'b0, "mr_p3");
        send(1'b0, 1'b1, "mr_p4");
        send(1'b0, 1'b0, "mr_b2");
        send(1'b1, 1'b0, "mr_b3");
        send(1'b1, 1'b0, "mr_b4");
        #2;
        reset = 1'b1;
        #1;
        check("mr_async_count", 32'(match_count), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("mr_cfg_err", 32'(cfg_err), 32'd0);
        send(1'b0, 1'b0, "mr_after0");
        send(1'b0, 1'b0, "mr_s1");
        send(1'b1, 1'b0, "mr_s2");
        send(1'b1, 1'b0, "mr_s3");
        send(1'b0, 1'b1, "mr_s4");
        idle("mr_after");
        check("mr_count", 32'(match_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (range 2..16).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Parameter LEN_W, default 5, width of cfg_len (at least clog2(MAX_LEN+1)).
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cfg_load  input  1  capture cfg_pattern, cfg_len and cfg_overlap this cycle.
REQ-007 cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
REQ-008 cfg_len  input  LEN_W  pattern length in bits.
REQ-009 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 x_valid  input  1  x is sampled only when this is 1.
REQ-011 x  input  1  serial data bit.
REQ-012 clear  input  1  synchronous clear of match_count.
REQ-013 z  output  1  registered one-cycle match pulse.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 cfg_err  output  1  loaded configuration is invalid.

Function
REQ-016 The block SHALL hold an active configuration (pattern, len, overlap) in registers, changed only by cfg_load or reset.
REQ-017 On cfg_load, the block SHALL capture all three config inputs, flush the bit history and bits_seen to 0, and ignore x_valid in that cycle.
REQ-018 The block SHALL set cfg_err to 1 whenever the active len is below 2 or above MAX_LEN; while cfg_err is 1, z SHALL stay 0 and match_count SHALL hold.
REQ-019 On each valid bit (x_valid=1, cfg_load=0), the block SHALL shift x into the LSB of the history register and increment bits_seen, saturating at len.
REQ-020 A match SHALL occur on a valid bit when bits_seen (after the increment) equals len and history[len-1:0] (after the shift) equals pattern[len-1:0].
REQ-021 On a match, z SHALL be 1 in the cycle after the sampling edge and 0 otherwise; latency is one clock from the final bit's sampling edge.
REQ-022 With cfg_overlap=1, the history SHALL be retained after a match so that a suffix can start the next match (pattern 0110 on stream 0110110 gives 2 matches).
REQ-023 With cfg_overlap=0, bits_seen SHALL reset to 0 after a match (pattern 0110 on stream 0110110 gives 1 match).
REQ-024 When x_valid=0, history, bits_seen and match_count SHALL hold, and z SHALL be 0 in the following cycle.
REQ-025 Each match SHALL increment match_count by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-026 clear SHALL set match_count to 0 at the next edge; if clear and a match coincide, clear SHALL win (count = 0) and z SHALL still pulse.
REQ-027 Bits of cfg_pattern at index len and above SHALL be ignored.

Reset
REQ-028 While reset is 1, the block SHALL set z=0, match_count=0, history=0 and bits_seen=0.
REQ-029 Reset SHALL also load the default configuration: pattern=4'b0110 zero-extended, len=4, overlap=0, cfg_err=0.
REQ-030 A reset asserted mid-sequence SHALL discard partial progress, so that matching restarts from the first bit after release.

Verification
REQ-031 Default config after reset, x_valid=1, stream 0,1,1,0 -> z=1 for exactly one cycle after the 4th edge, match_count=1.
REQ-032 Load pattern 0110/len 4/overlap=1, stream 0,1,1,0,1,1,0 -> z pulses after bits 4 and 7, match_count=2; repeat with overlap=0 -> one pulse, count=1.
REQ-033 Load len=1 -> cfg_err=1, stream of any bits -> z=0, count unchanged; load len=8, pattern 8'hA5 -> cfg_err=0, stream 10100101 -> one pulse.
REQ-034 Insert x_valid=0 gaps between bits of 0110 -> match still detected, z pulses once after the last valid bit.
REQ-035 Preload count to 255 (CNT_W=8) via repeated matches, one more match -> count stays 255; clear coincident with a match -> count=0, z=1.
REQ-036 Assert reset after bits 0,1,1, release, then send 0 -> no pulse; a full 0,1,1,0 afterwards -> one pulse.
